// File: rtl/systolic_seq.sv
// Sequencer for the DIM x DIM systolic multiply: operand row-write tracking, wavefront enable, result readback.
// Optional cycle counter on perf_cycles is built only when SYSTOLIC_SEQ_PERF_EN is defined.
module systolic_seq #(
  parameter int DIM = 8,
  parameter int CW  = $clog2(3*DIM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic                     wr_sel,
  input  logic [$clog2(DIM)-1:0]   wr_row,
  output logic                     wr_ready,
  input  logic                     start,
  output logic                     start_err,
  output logic                     a_wren,
  output logic                     b_wren,
  output logic [$clog2(DIM)-1:0]   wr_row_q,
  output logic                     mem_en,
  output logic                     c_valid,
  output logic [$clog2(DIM)-1:0]   c_row,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              perf_cycles
);

  localparam int RW = $clog2(DIM);
  localparam logic [CW-1:0] COMP_LAST = CW'(3*DIM-3);
  localparam logic [RW-1:0] ROW_LAST  = RW'(DIM-1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_READ, S_DONE} state_t;

  state_t          r_state;
  logic [DIM-1:0]  r_a_mask;
  logic [DIM-1:0]  r_b_mask;
  logic [CW-1:0]   r_cnt;
  logic            r_a_wren;
  logic            r_b_wren;
  logic [RW-1:0]   r_wr_row_q;
  logic            r_mem_en;
  logic            r_c_valid;
  logic [RW-1:0]   r_c_row;
  logic            r_done;
  logic            r_start_err;

  logic [DIM-1:0]  w_row_dec;
  logic            w_idle;
  logic            w_full;
  logic            w_start_acc;

  for (genvar gi = 0; gi < DIM; gi++) begin : g_row_dec
    assign w_row_dec[gi] = (wr_row == RW'(gi));
  end

  assign w_idle      = (r_state == S_IDLE);
  assign w_full      = (&r_a_mask) && (&r_b_mask);
  // A write in the same cycle wins over start; start is then silently dropped.
  assign w_start_acc = w_idle && !wr_valid && start && w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_mask    <= '0;
      r_b_mask    <= '0;
      r_cnt       <= '0;
      r_a_wren    <= 1'b0;
      r_b_wren    <= 1'b0;
      r_wr_row_q  <= '0;
      r_mem_en    <= 1'b0;
      r_c_valid   <= 1'b0;
      r_c_row     <= '0;
      r_done      <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_a_wren    <= 1'b0;
      r_b_wren    <= 1'b0;
      r_done      <= 1'b0;
      r_start_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_valid) begin
            r_a_wren   <= !wr_sel;
            r_b_wren   <= wr_sel;
            r_wr_row_q <= wr_row;
            if (wr_sel) r_b_mask <= r_b_mask | w_row_dec;
            else        r_a_mask <= r_a_mask | w_row_dec;
          end else if (start) begin
            if (w_start_acc) begin
              r_state  <= S_COMPUTE;
              r_mem_en <= 1'b1;
              r_cnt    <= '0;
            end else begin
              r_start_err <= 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          // 3*DIM-2 enable cycles let the skewed wavefront drain through the array.
          if (r_cnt == COMP_LAST) begin
            r_mem_en  <= 1'b0;
            r_c_valid <= 1'b1;
            r_c_row   <= '0;
            r_state   <= S_READ;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (r_c_row == ROW_LAST) begin
            r_c_valid <= 1'b0;
            r_c_row   <= '0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_c_row <= r_c_row + 1'b1;
          end
        end
        S_DONE: begin
          r_a_mask <= '0;
          r_b_mask <= '0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_ready  = w_idle;
  assign busy      = !w_idle;
  assign a_wren    = r_a_wren;
  assign b_wren    = r_b_wren;
  assign wr_row_q  = r_wr_row_q;
  assign mem_en    = r_mem_en;
  assign c_valid   = r_c_valid;
  assign c_row     = r_c_row;
  assign done      = r_done;
  assign start_err = r_start_err;

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [31:0] r_perf;

  // Counts the accept cycle plus every COMPUTE/READ cycle, so the done cycle
  // already shows the full start-to-done latency and it is held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= '0;
    end else if (w_start_acc) begin
      r_perf <= 32'd1;
    end else if ((r_state == S_COMPUTE || r_state == S_READ) && (r_perf != '1)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Scoreboard bench for systolic_seq: stimulus pushes timed expectations, a negedge monitor pops and compares.
module tb_systolic_seq;
  localparam int DIM = 8;
  localparam int RW  = $clog2(DIM);
  localparam int CW  = $clog2(3*DIM);
`ifdef SYSTOLIC_SEQ_PERF_EN
  localparam int PERF_EXP = 4*DIM-1;
`else
  localparam int PERF_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_sel = 1'b0;
  logic [RW-1:0] wr_row = '0;
  logic          start = 1'b0;
  logic          wr_ready, start_err, a_wren, b_wren, mem_en, c_valid, busy, done;
  logic [RW-1:0] wr_row_q, c_row;
  logic [31:0]   perf_cycles;

  systolic_seq #(.DIM(DIM), .CW(CW)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_ready(wr_ready), .start(start), .start_err(start_err), .a_wren(a_wren),
    .b_wren(b_wren), .wr_row_q(wr_row_q), .mem_en(mem_en), .c_valid(c_valid),
    .c_row(c_row), .busy(busy), .done(done), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int v; } ev_t;
  ev_t wq[$];
  ev_t cq[$];
  ev_t dq[$];
  ev_t eq[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: which rows are loaded, and the expected activity windows.
  int a_w[DIM];
  int b_w[DIM];
  int idle_at = 0;
  int mem_lo = 1, mem_hi = 0;
  int busy_lo = 1, busy_hi = 0;
  int mon_from = 1 << 30;
  int rst_chk = -1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic bit ops_full();
    for (int i = 0; i < DIM; i++) if (a_w[i] == 0 || b_w[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_ops();
    for (int i = 0; i < DIM; i++) begin a_w[i] = 0; b_w[i] = 0; end
  endtask

  task automatic step(input logic r, input logic wv, input logic s, input int row, input logic st);
    int k;
    @(posedge clk); #1;
    rst = r; wr_valid = wv; wr_sel = s; wr_row = RW'(row); start = st;
    k = cyc;
    if (r) begin
      while (wq.size() > 0 && wq[$].cyc > k) void'(wq.pop_back());
      while (cq.size() > 0 && cq[$].cyc > k) void'(cq.pop_back());
      while (dq.size() > 0 && dq[$].cyc > k) void'(dq.pop_back());
      while (eq.size() > 0 && eq[$].cyc > k) void'(eq.pop_back());
      clear_ops();
      if (mem_hi > k) mem_hi = k;
      if (busy_hi > k) busy_hi = k;
      idle_at = k + 1;
      rst_chk = k + 1;
      if (mon_from > k + 1) mon_from = k + 1;
    end else if (k >= idle_at) begin
      if (wv) begin
        wq.push_back('{k + 1, (s ? 256 : 512) + row});
        if (s) b_w[row] = 1; else a_w[row] = 1;
      end else if (st) begin
        if (ops_full()) begin
          mem_lo = k + 1;  mem_hi = k + 3*DIM - 2;
          busy_lo = k + 1; busy_hi = k + 4*DIM - 1;
          idle_at = k + 4*DIM;
          for (int i = 0; i < DIM; i++) cq.push_back('{k + 3*DIM - 1 + i, i});
          dq.push_back('{k + 4*DIM - 1, PERF_EXP});
          clear_ops();
        end else begin
          eq.push_back('{k + 1, 1});
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Random write/start traffic; used while the sequencer is busy so it must be ignored.
  task automatic noise(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, DIM - 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic load_all_shuffled();
    int perm[2*DIM];
    int j, t;
    for (int i = 0; i < 2*DIM; i++) perm[i] = i;
    for (int i = 2*DIM - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 2*DIM; i++) step(1'b0, 1'b1, 1'(perm[i] / DIM), perm[i] % DIM, 1'b0);
  endtask

  ev_t e_m;
  logic exp_mem, exp_busy;
  always @(negedge clk) begin
    if (cyc >= mon_from) begin
      exp_mem  = (cyc >= mem_lo) && (cyc <= mem_hi);
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("mem_en", int'(mem_en), int'(exp_mem));
      chk("busy", int'(busy), int'(exp_busy));
      chk("wr_ready", int'(wr_ready), int'(!exp_busy));

      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        chk("missing_wren", 0, wq[0].v); void'(wq.pop_front());
      end
      if (a_wren || b_wren) begin
        if (wq.size() == 0 || wq[0].cyc != cyc) chk("unexpected_wren", 1, 0);
        else begin
          e_m = wq.pop_front();
          chk("wren_row", (a_wren ? 512 : 0) + (b_wren ? 256 : 0) + int'(wr_row_q), e_m.v);
        end
      end

      while (cq.size() > 0 && cq[0].cyc < cyc) begin
        chk("missing_c_valid", 0, 1); void'(cq.pop_front());
      end
      if (c_valid) begin
        if (cq.size() == 0 || cq[0].cyc != cyc) chk("unexpected_c_valid", 1, 0);
        else begin
          e_m = cq.pop_front();
          chk("c_row", int'(c_row), e_m.v);
        end
      end

      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        chk("missing_done", 0, 1); void'(dq.pop_front());
      end
      if (done) begin
        if (dq.size() == 0 || dq[0].cyc != cyc) chk("unexpected_done", 1, 0);
        else begin
          e_m = dq.pop_front();
          chk("perf_cycles", int'(perf_cycles), e_m.v);
        end
      end

      while (eq.size() > 0 && eq[0].cyc < cyc) begin
        chk("missing_start_err", 0, 1); void'(eq.pop_front());
      end
      if (start_err) begin
        if (eq.size() == 0 || eq[0].cyc != cyc) chk("unexpected_start_err", 1, 0);
        else begin
          e_m = eq.pop_front();
          chk("start_err", 1, e_m.v);
        end
      end

      if (cyc == rst_chk) begin
        chk("rst_c_row", int'(c_row), 0);
        chk("rst_wr_row_q", int'(wr_row_q), 0);
        chk("rst_perf", int'(perf_cycles), 0);
      end
    end
  end

  initial begin
    clear_ops();
    repeat (3) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(2);

    // Full load A then B back-to-back, start, ignored traffic while busy.
    for (int r = 0; r < DIM; r++) step(1'b0, 1'b1, 1'b0, r, 1'b0);
    for (int r = 0; r < DIM; r++) step(1'b0, 1'b1, 1'b1, r, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    noise(4*DIM - 1);
    idle(2);

    // Incomplete operands: B row DIM-1 missing.
    for (int r = 0; r < DIM; r++) step(1'b0, 1'b1, 1'b0, r, 1'b0);
    for (int r = 0; r < DIM - 1; r++) step(1'b0, 1'b1, 1'b1, r, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(2);

    // Completing write with start in the same cycle, then a real start.
    step(1'b0, 1'b1, 1'b1, DIM - 1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    noise(4*DIM - 1);
    idle(1);

    // Masks are cleared after done.
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(2);

    // Reset in the 10th mem_en cycle, then an immediate start.
    load_all_shuffled();
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    noise(9);
    step(1'b1, 1'b1, 1'b1, 3, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(2);

    // Two identical full sequences.
    repeat (2) begin
      load_all_shuffled();
      step(1'b0, 1'b0, 1'b0, 0, 1'b1);
      noise(4*DIM - 1);
      idle(1);
    end

    // Free-running random traffic including occasional resets.
    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 1)), int'($urandom_range(0, DIM - 1)),
           1'($urandom_range(0, 9) == 0));

    idle(4*DIM + 4);
    @(negedge clk); #1;
    chk("wq_drained", wq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    chk("eq_drained", eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
